// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: load-use stall FSM, taken-branch flush and EX-stage forwarding selects.
// Optional stall/flush performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  idex_memread,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic [REG_ADDR_W-1:0] ifid_rs1,
  input  logic [REG_ADDR_W-1:0] ifid_rs2,
  input  logic [REG_ADDR_W-1:0] idex_rs1,
  input  logic [REG_ADDR_W-1:0] idex_rs2,
  input  logic                  exmem_regwrite,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  memwb_regwrite,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  branch_taken,
  output logic                  controlmux,
  output logic                  pcen,
  output logic                  ifiden,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_total,
  output logic [31:0]           flush_total
`endif
);

  typedef enum logic {IDLE, STALL} state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t                     state;
  logic [CNT_W-1:0]           cnt;
  logic                       lu;
  logic                       stall;
  logic [1:0][REG_ADDR_W-1:0] ex_rs;
  logic [1:0][1:0]            fwd;

  assign lu = idex_memread && (idex_rd != '0) &&
              ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

  // The first stall cycle comes straight from lu; STALL covers the remaining LOAD_LAT-1.
  assign stall = (state == STALL) || lu;

  assign ex_rs = {idex_rs2, idex_rs1};

  // One forwarding selector per ALU operand; EX/MEM has priority over MEM/WB.
  for (genvar i = 0; i < 2; i++) begin : g_fwd
    assign fwd[i] = (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == ex_rs[i])) ? 2'b10 :
                    (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == ex_rs[i])) ? 2'b01 :
                    2'b00;
  end

  always_comb begin
    pcen       = 1'b1;
    ifiden     = 1'b1;
    controlmux = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    forward_a  = 2'b00;
    forward_b  = 2'b00;
    if (!rst) begin
      forward_a = fwd[0];
      forward_b = fwd[1];
      if (branch_taken) begin
        controlmux = 1'b0;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (stall) begin
        pcen       = 1'b0;
        ifiden     = 1'b0;
        controlmux = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || branch_taken) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lu && (LOAD_LAT > 1)) begin
            state <= STALL;
            cnt   <= CNT_INIT;
          end
        end
        STALL: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_total <= '0;
      flush_total <= '0;
    end else begin
      if (!pcen)        stall_total <= stall_total + 32'd1;
      if (branch_taken) flush_total <= flush_total + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: three instances (LOAD_LAT = 1, 2, 3) share one input bus.
module tb_hazard_ctrl_unit;
  localparam int RW = 5;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst;
  logic idex_memread, exmem_regwrite, memwb_regwrite, branch_taken;
  logic [RW-1:0] idex_rd, ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, exmem_rd, memwb_rd;
  logic [NI-1:0] controlmux, pcen, ifiden, ifid_flush, idex_flush;
  logic [NI-1:0][1:0] forward_a, forward_b;
`ifdef HAZARD_PERF_CNT_EN
  logic [NI-1:0][31:0] stall_total, flush_total;
`endif

  int checks = 0;
  int failures = 0;
  int rem[NI];
  int unsigned ps[NI];
  int unsigned pf[NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    hazard_ctrl_unit #(.REG_ADDR_W(RW), .LOAD_LAT(g + 1), .CNT_W(4)) u_dut (
      .clk(clk), .rst(rst),
      .idex_memread(idex_memread), .idex_rd(idex_rd),
      .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
      .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
      .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
      .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
      .branch_taken(branch_taken),
      .controlmux(controlmux[g]), .pcen(pcen[g]), .ifiden(ifiden[g]),
      .ifid_flush(ifid_flush[g]), .idex_flush(idex_flush[g]),
      .forward_a(forward_a[g]), .forward_b(forward_b[g])
`ifdef HAZARD_PERF_CNT_EN
      , .stall_total(stall_total[g]), .flush_total(flush_total[g])
`endif
    );
  end

  typedef struct {
    logic          exw;
    logic [RW-1:0] exrd;
    logic          wbw;
    logic [RW-1:0] wbrd;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [1:0]    fa;
    logic [1:0]    fb;
  } fwd_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic lu_now();
    return idex_memread && (idex_rd != 0) && ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
  endfunction

  function automatic logic [1:0] fwd_ref(input logic [RW-1:0] rs);
    if (exmem_regwrite && exmem_rd != 0 && exmem_rd == rs) return 2'b10;
    if (memwb_regwrite && memwb_rd != 0 && memwb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  // rem[i] = stall cycles still owed after the current one for instance i.
  function automatic logic exp_stall(input int i);
    return !rst && !branch_taken && (rem[i] > 0 || lu_now());
  endfunction

  task automatic model_update();
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        rem[i] = 0; ps[i] = 0; pf[i] = 0;
      end else begin
        if (exp_stall(i)) ps[i]++;
        if (branch_taken) pf[i]++;
        if (branch_taken)    rem[i] = 0;
        else if (rem[i] > 0) rem[i]--;
        else if (lu_now())   rem[i] = i;  // LOAD_LAT-1 further cycles
      end
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < NI; i++) begin
      logic es;
      es = exp_stall(i);
      chk($sformatf("rnd.pcen[%0d]", i), pcen[i], rst || branch_taken || !es);
      chk($sformatf("rnd.ifiden[%0d]", i), ifiden[i], rst || branch_taken || !es);
      chk($sformatf("rnd.controlmux[%0d]", i), controlmux[i], rst || (!branch_taken && !es));
      chk($sformatf("rnd.ifid_flush[%0d]", i), ifid_flush[i], !rst && branch_taken);
      chk($sformatf("rnd.idex_flush[%0d]", i), idex_flush[i], !rst && branch_taken);
      chk($sformatf("rnd.forward_a[%0d]", i), forward_a[i], rst ? 2'b00 : fwd_ref(idex_rs1));
      chk($sformatf("rnd.forward_b[%0d]", i), forward_b[i], rst ? 2'b00 : fwd_ref(idex_rs2));
`ifdef HAZARD_PERF_CNT_EN
      chk($sformatf("rnd.stall_total[%0d]", i), stall_total[i], ps[i]);
      chk($sformatf("rnd.flush_total[%0d]", i), flush_total[i], pf[i]);
`endif
    end
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic chk_en(input string n, input logic [NI-1:0] e);
    chk({n, ".pcen"}, pcen, e);
    chk({n, ".ifiden"}, ifiden, e);
    chk({n, ".controlmux"}, controlmux, e);
    chk({n, ".flush"}, {ifid_flush, idex_flush}, 0);
  endtask

  task automatic cyc(input string n, input logic [NI-1:0] e);
    @(negedge clk);
    chk_en(n, e);
    adv();
  endtask

  task automatic clr();
    idex_memread = 0; idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
    idex_rs1 = 0; idex_rs2 = 0; exmem_regwrite = 0; exmem_rd = 0;
    memwb_regwrite = 0; memwb_rd = 0; branch_taken = 0;
  endtask

  task automatic haz();
    idex_memread = 1; idex_rd = 5; ifid_rs1 = 2; ifid_rs2 = 5;
  endtask

  initial begin
    fwd_vec_t tbl[9];
    tbl[0] = '{1, 7, 1, 7, 7, 0, 2'b10, 2'b00};
    tbl[1] = '{0, 7, 1, 7, 7, 7, 2'b01, 2'b01};
    tbl[2] = '{1, 0, 1, 0, 0, 0, 2'b00, 2'b00};
    tbl[3] = '{1, 3, 1, 4, 4, 3, 2'b01, 2'b10};
    tbl[4] = '{1, 3, 0, 4, 4, 3, 2'b00, 2'b10};
    tbl[5] = '{0, 3, 0, 4, 3, 4, 2'b00, 2'b00};
    tbl[6] = '{1, 9, 1, 9, 9, 9, 2'b10, 2'b10};
    tbl[7] = '{1, 0, 1, 6, 0, 6, 2'b00, 2'b01};
    tbl[8] = '{1, 7, 1, 7, 8, 8, 2'b00, 2'b00};

    // Reset forces the outputs even with a hazard and a forwarding match present.
    clr(); haz();
    exmem_regwrite = 1; exmem_rd = 7; idex_rs1 = 7;
    rst = 1;
    cyc("rst.force", 3'b111);
    @(negedge clk);
    chk("rst.forward_a", forward_a, 0);
    adv();
    rst = 0; clr();
    cyc("idle", 3'b111);

    // Load-use: each instance stalls exactly LOAD_LAT cycles.
    haz();
    cyc("lu.c0", 3'b000);
    clr();
    cyc("lu.c1", 3'b001);
    cyc("lu.c2", 3'b011);
    cyc("lu.c3", 3'b111);
    idex_memread = 1;
    cyc("lu.rd0", 3'b111);
    clr();

    // Branch in the second stall cycle aborts the stall.
    haz();
    cyc("br.c0", 3'b000);
    clr(); branch_taken = 1;
    @(negedge clk);
    chk("br.pcen", pcen, 3'b111);
    chk("br.ifiden", ifiden, 3'b111);
    chk("br.controlmux", controlmux, 3'b000);
    chk("br.ifid_flush", ifid_flush, 3'b111);
    chk("br.idex_flush", idex_flush, 3'b111);
    adv();
    branch_taken = 0;
    cyc("br.after", 3'b111);

    // Reset mid-stall, then a fresh hazard gets the full stall.
    haz();
    cyc("rs.c0", 3'b000);
    clr(); rst = 1;
    cyc("rs.c1", 3'b111);
    rst = 0;
    cyc("rs.idle", 3'b111);
    haz();
    cyc("rs.re0", 3'b000);
    clr();
    cyc("rs.re1", 3'b001);
    cyc("rs.re2", 3'b011);
    cyc("rs.re3", 3'b111);

    foreach (tbl[k]) begin
      exmem_regwrite = tbl[k].exw; exmem_rd = tbl[k].exrd;
      memwb_regwrite = tbl[k].wbw; memwb_rd = tbl[k].wbrd;
      idex_rs1 = tbl[k].rs1; idex_rs2 = tbl[k].rs2;
      @(negedge clk);
      chk($sformatf("fwd[%0d].a", k), forward_a, {3{tbl[k].fa}});
      chk($sformatf("fwd[%0d].b", k), forward_b, {3{tbl[k].fb}});
      adv();
    end
    clr();

`ifdef HAZARD_PERF_CNT_EN
    rst = 1;
    cyc("p.rst", 3'b111);
    rst = 0;
    repeat (2) begin
      haz();
      cyc("p.c0", 3'b000);
      clr();
      cyc("p.c1", 3'b001);
      cyc("p.c2", 3'b011);
      cyc("p.c3", 3'b111);
    end
    branch_taken = 1;
    @(negedge clk);
    adv();
    branch_taken = 0;
    @(negedge clk);
    chk("p.stall_total[1]", stall_total[1], 4);
    chk("p.flush_total[1]", flush_total[1], 1);
    chk("p.stall_total[0]", stall_total[0], 2);
    chk("p.stall_total[2]", stall_total[2], 6);
    adv();
`endif

    // Random traffic against the reference model; small register range to force matches.
    repeat (3000) begin
      rst            = ($urandom_range(0, 39) == 0);
      idex_memread   = 1'($urandom_range(0, 1));
      idex_rd        = RW'($urandom_range(0, 3));
      ifid_rs1       = RW'($urandom_range(0, 3));
      ifid_rs2       = RW'($urandom_range(0, 3));
      idex_rs1       = RW'($urandom_range(0, 3));
      idex_rs2       = RW'($urandom_range(0, 3));
      exmem_regwrite = 1'($urandom_range(0, 1));
      exmem_rd       = RW'($urandom_range(0, 3));
      memwb_regwrite = 1'($urandom_range(0, 1));
      memwb_rd       = RW'($urandom_range(0, 3));
      branch_taken   = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      check_model();
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
